// File: rtl/cpu_control_pkg.sv
// cpu_control_pkg: RV32I opcode/funct encodings, datapath select enums and control FSM state codes
package cpu_control_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
    } alu_ops;

    typedef enum logic [2:0] {
        beq = 3'd0, bne = 3'd1, blt = 3'd4, bge = 3'd5, bltu = 3'd6, bgeu = 3'd7
    } branch_funct3_t;

    typedef enum logic [2:0] {
        f3_add = 3'd0, f3_sll = 3'd1, f3_slt = 3'd2, f3_sltu = 3'd3,
        f3_xor = 3'd4, f3_sr = 3'd5, f3_or = 3'd6, f3_and = 3'd7
    } arith_funct3_t;

    typedef enum logic [2:0] {
        lb = 3'd0, lh = 3'd1, lw = 3'd2, lbu = 3'd4, lhu = 3'd5
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'd0, sh = 3'd1, sw = 3'd2
    } store_funct3_t;

    typedef enum logic [1:0] {
        pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2
    } pcmux_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_rs2, alumux2_j_imm
    } alumux2_sel_t;

    typedef enum logic [2:0] {
        rfmux_alu_out, rfmux_br_en, rfmux_u_imm, rfmux_mdr, rfmux_pc_plus4
    } regfilemux_sel_t;

    typedef enum logic {
        marmux_pc, marmux_alu
    } marmux_sel_t;

    // Control FSM state codes, kept as plain constants so older tools can consume them
    typedef logic [3:0] ctrl_state_t;
    localparam ctrl_state_t S_FETCH1    = 4'd0;
    localparam ctrl_state_t S_FETCH2    = 4'd1;
    localparam ctrl_state_t S_FETCH3    = 4'd2;
    localparam ctrl_state_t S_DECODE    = 4'd3;
    localparam ctrl_state_t S_IMM       = 4'd4;
    localparam ctrl_state_t S_REG       = 4'd5;
    localparam ctrl_state_t S_LUI       = 4'd6;
    localparam ctrl_state_t S_AUIPC     = 4'd7;
    localparam ctrl_state_t S_BR        = 4'd8;
    localparam ctrl_state_t S_JAL       = 4'd9;
    localparam ctrl_state_t S_JALR      = 4'd10;
    localparam ctrl_state_t S_CALC_ADDR = 4'd11;
    localparam ctrl_state_t S_LD1       = 4'd12;
    localparam ctrl_state_t S_LD2       = 4'd13;
    localparam ctrl_state_t S_ST1       = 4'd14;
    localparam ctrl_state_t S_HALT      = 4'd15;

    // ALU op for op-imm / op-reg: funct7[5] selects sra on shifts, and sub only for register adds
    function automatic alu_ops alu_op_of(logic [2:0] f3, logic alt, logic is_reg);
        return (f3 == f3_sr && alt) ? alu_sra :
               (f3 == f3_add && alt && is_reg) ? alu_sub : alu_ops'(f3);
    endfunction

endpackage

// File: rtl/cpu_control_if.sv
// cpu_control_if: control <-> datapath/memory bundle; master is the control FSM side
interface cpu_control_if
    import cpu_control_pkg::*;
();
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            br_en;
    logic [1:0]      mem_addr_lo;
    logic            mem_resp;
    pcmux_sel_t      pcmux_sel;
    logic            alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    logic            cmpmux_sel;
    logic [2:0]      mdrmux_sel;
    logic [1:0]      mem_data_out_sel;
    alu_ops          aluop;
    logic [2:0]      cmpop;
    logic            load_pc;
    logic            load_ir;
    logic            load_regfile;
    logic            load_mar;
    logic            load_mdr;
    logic            load_data_out;
    logic            mem_read;
    logic            mem_write;
    logic [3:0]      mem_byte_enable;

    modport master (
        input  opcode, funct3, funct7, br_en, mem_addr_lo, mem_resp,
        output pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel,
               mdrmux_sel, mem_data_out_sel, aluop, cmpop,
               load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
               mem_read, mem_write, mem_byte_enable
    );

    modport slave (
        output opcode, funct3, funct7, br_en, mem_addr_lo, mem_resp,
        input  pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel,
               mdrmux_sel, mem_data_out_sel, aluop, cmpop,
               load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
               mem_read, mem_write, mem_byte_enable
    );
endinterface

// File: rtl/cpu_control_store_mask.sv
// cpu_control_store_mask: byte-lane enables for sb/sh/sw from funct3 and the MAR low bits
module cpu_control_store_mask
    import cpu_control_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] mem_addr_lo_i,
    output logic [3:0] mem_byte_enable_o
);
    // Misaligned halves shift lanes off the top; the address is used as-is, no trap
    always_comb begin
        mem_byte_enable_o = (funct3_i == sb) ? 4'b0001 << mem_addr_lo_i :
                            (funct3_i == sh) ? 4'b0011 << mem_addr_lo_i : 4'hF;
    end
endmodule

// File: rtl/cpu_control.sv
// cpu_control: multicycle RV32I control FSM driving datapath selects, register loads and the shared memory port
module cpu_control
    import cpu_control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input logic            clk,
    input logic            rst,
    cpu_control_if.master  bus
);
    ctrl_state_t state_q, state_d;
    logic [3:0]  st_mask;
    logic        is_slt;

    cpu_control_store_mask u_mask (
        .funct3_i          (bus.funct3),
        .mem_addr_lo_i     (bus.mem_addr_lo),
        .mem_byte_enable_o (st_mask)
    );

    assign is_slt = bus.funct3 == f3_slt || bus.funct3 == f3_sltu;

    // Next state and all control outputs; reset holds everything at defaults
    always_comb begin
        state_d              = state_q;
        bus.pcmux_sel        = pcmux_pc_plus4;
        bus.alumux1_sel      = 1'b0;
        bus.alumux2_sel      = alumux2_i_imm;
        bus.regfilemux_sel   = rfmux_alu_out;
        bus.marmux_sel       = marmux_pc;
        bus.cmpmux_sel       = 1'b0;
        bus.mdrmux_sel       = lw;
        bus.mem_data_out_sel = 2'd0;
        bus.aluop            = alu_add;
        bus.cmpop            = beq;
        bus.load_pc          = 1'b0;
        bus.load_ir          = 1'b0;
        bus.load_regfile     = 1'b0;
        bus.load_mar         = 1'b0;
        bus.load_mdr         = 1'b0;
        bus.load_data_out    = 1'b0;
        bus.mem_read         = 1'b0;
        bus.mem_write        = 1'b0;
        bus.mem_byte_enable  = 4'hF;
        if (rst) begin
            state_d = S_FETCH1;
        end else begin
            case (state_q)
                S_FETCH1: begin
                    bus.load_mar = 1'b1;
                    state_d      = S_FETCH2;
                end
                S_FETCH2: begin
                    bus.mem_read = 1'b1;
                    bus.load_mdr = bus.mem_resp;
                    state_d      = bus.mem_resp ? S_FETCH3 : S_FETCH2;
                end
                S_FETCH3: begin
                    bus.load_ir = 1'b1;
                    state_d     = S_DECODE;
                end
                S_DECODE: begin
                    case (bus.opcode)
                        op_imm:   state_d = S_IMM;
                        op_reg:   state_d = S_REG;
                        op_lui:   state_d = S_LUI;
                        op_auipc: state_d = S_AUIPC;
                        op_br:    state_d = S_BR;
                        op_jal:   state_d = S_JAL;
                        op_jalr:  state_d = S_JALR;
                        op_load,
                        op_store: state_d = S_CALC_ADDR;
                        default: begin
                            bus.load_pc = !HALT_ON_ILLEGAL;
                            state_d     = HALT_ON_ILLEGAL ? S_HALT : S_FETCH1;
                        end
                    endcase
                end
                S_IMM, S_REG: begin
                    bus.alumux2_sel    = (state_q == S_REG) ? alumux2_rs2 : alumux2_i_imm;
                    bus.cmpmux_sel     = state_q == S_IMM;
                    bus.cmpop          = (bus.funct3 == f3_slt) ? blt : bltu;
                    bus.regfilemux_sel = is_slt ? rfmux_br_en : rfmux_alu_out;
                    bus.aluop          = alu_op_of(bus.funct3, bus.funct7[5], state_q == S_REG);
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    state_d            = S_FETCH1;
                end
                S_LUI: begin
                    bus.regfilemux_sel = rfmux_u_imm;
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    state_d            = S_FETCH1;
                end
                S_AUIPC: begin
                    bus.alumux1_sel  = 1'b1;
                    bus.alumux2_sel  = alumux2_u_imm;
                    bus.load_regfile = 1'b1;
                    bus.load_pc      = 1'b1;
                    state_d          = S_FETCH1;
                end
                S_BR: begin
                    bus.cmpop       = bus.funct3;
                    bus.alumux1_sel = 1'b1;
                    bus.alumux2_sel = alumux2_b_imm;
                    bus.pcmux_sel   = bus.br_en ? pcmux_alu_out : pcmux_pc_plus4;
                    bus.load_pc     = 1'b1;
                    state_d         = S_FETCH1;
                end
                S_JAL, S_JALR: begin
                    bus.alumux1_sel    = state_q == S_JAL;
                    bus.alumux2_sel    = (state_q == S_JAL) ? alumux2_j_imm : alumux2_i_imm;
                    bus.pcmux_sel      = (state_q == S_JAL) ? pcmux_alu_out : pcmux_alu_mod2;
                    bus.regfilemux_sel = rfmux_pc_plus4;
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    state_d            = S_FETCH1;
                end
                S_CALC_ADDR: begin
                    bus.alumux2_sel      = (bus.opcode == op_store) ? alumux2_s_imm : alumux2_i_imm;
                    bus.marmux_sel       = marmux_alu;
                    bus.load_mar         = 1'b1;
                    bus.load_data_out    = bus.opcode == op_store;
                    bus.mem_data_out_sel = (bus.opcode == op_store) ? bus.funct3[1:0] : 2'd0;
                    state_d              = (bus.opcode == op_store) ? S_ST1 : S_LD1;
                end
                S_LD1: begin
                    bus.mem_read = 1'b1;
                    bus.load_mdr = bus.mem_resp;
                    state_d      = bus.mem_resp ? S_LD2 : S_LD1;
                end
                S_LD2: begin
                    bus.mdrmux_sel     = bus.funct3;
                    bus.regfilemux_sel = rfmux_mdr;
                    bus.load_regfile   = 1'b1;
                    bus.load_pc        = 1'b1;
                    state_d            = S_FETCH1;
                end
                S_ST1: begin
                    bus.mem_write       = 1'b1;
                    bus.mem_byte_enable = st_mask;
                    bus.load_pc         = bus.mem_resp;
                    state_d             = bus.mem_resp ? S_FETCH1 : S_ST1;
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_FETCH1;
            endcase
        end
    end

    // State register with synchronous reset to FETCH1
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH1;
        else     state_q <= state_d;
    end
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: directed checks of cpu_control sequencing, selects and memory handshake
module tb_cpu_control;
    import cpu_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'h00;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       br_en = 1'b0;
    logic [1:0] addr_lo = 2'd0;
    int         wait_n = 0;
    int         cnt = 0;
    int         tests = 0;
    int         fails = 0;

    int         n_cyc, n_pc, n_rf, n_wr, n_ldo, act;
    logic [1:0] pc_sel;
    logic [2:0] pc_cmpop, rf_sel, rf_aluop, rf_mdr, rf_cmpop;
    logic       rf_cmpmux;
    logic [3:0] wr_be;

    always #5 clk = ~clk;

    cpu_control_if cb ();
    cpu_control_if hb ();

    assign cb.opcode = opcode;
    assign cb.funct3 = funct3;
    assign cb.funct7 = funct7;
    assign cb.br_en = br_en;
    assign cb.mem_addr_lo = addr_lo;
    assign hb.opcode = opcode;
    assign hb.funct3 = funct3;
    assign hb.funct7 = funct7;
    assign hb.br_en = br_en;
    assign hb.mem_addr_lo = addr_lo;

    // Memory model: response arrives after wait_n full strobe cycles (0 = same cycle)
    always @(posedge clk) cnt <= ((cb.mem_read || cb.mem_write) && !cb.mem_resp) ? cnt + 1 : 0;
    assign cb.mem_resp = (cb.mem_read || cb.mem_write) && cnt == wait_n;
    assign hb.mem_resp = hb.mem_read || hb.mem_write;

    cpu_control #(.HALT_ON_ILLEGAL(1'b0)) dut (.clk(clk), .rst(rst), .bus(cb));
    cpu_control #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (.clk(clk), .rst(rst), .bus(hb));

    // Runs one instruction starting at a negedge in FETCH1, ends at the next FETCH1
    task automatic run_instr(input int fw, input int dw);
        n_cyc = 0; n_pc = 0; n_rf = 0; n_wr = 0; n_ldo = 0;
        pc_sel = 'x; pc_cmpop = 'x; rf_sel = 'x; rf_aluop = 'x; rf_mdr = 'x; rf_cmpop = 'x;
        rf_cmpmux = 'x; wr_be = 'x;
        wait_n = fw;
        do begin
            if (cb.load_pc) begin n_pc++; pc_sel = cb.pcmux_sel; pc_cmpop = cb.cmpop; end
            if (cb.load_regfile) begin
                n_rf++; rf_sel = cb.regfilemux_sel; rf_aluop = cb.aluop;
                rf_mdr = cb.mdrmux_sel; rf_cmpop = cb.cmpop; rf_cmpmux = cb.cmpmux_sel;
            end
            if (cb.mem_write) begin n_wr++; wr_be = cb.mem_byte_enable; end
            if (cb.load_data_out) n_ldo++;
            if (cb.load_mar && cb.marmux_sel == marmux_alu) wait_n = dw;
            n_cyc++;
            @(negedge clk);
        end while (!(cb.load_mar && cb.marmux_sel == marmux_pc) && n_cyc < 60);
        tests++;
        if (n_cyc >= 60) begin fails++; $display("FAIL timeout: instr cycles %0d, limit 60", n_cyc); end
    endtask

    task automatic test_reset();
        wait_n = 1000;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (cb.load_mar !== 1'b1 || cb.marmux_sel !== marmux_pc) begin
            fails++; $display("FAIL reset_fetch1: load_mar %0d marmux %0d, want 1 0", cb.load_mar, cb.marmux_sel);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (cb.mem_read !== 1'b1) begin fails++; $display("FAIL fetch2_stall: mem_read %0d, want 1", cb.mem_read); end
        rst = 1'b1;
        #1;
        tests++;
        if (cb.mem_read !== 1'b0 || cb.load_mdr !== 1'b0) begin
            fails++; $display("FAIL reset_drop: mem_read %0d load_mdr %0d, want 0 0", cb.mem_read, cb.load_mdr);
        end
        @(negedge clk);
        tests++;
        if (cb.mem_read !== 1'b0 || cb.load_mar !== 1'b0) begin
            fails++; $display("FAIL reset_hold: mem_read %0d load_mar %0d, want 0 0", cb.mem_read, cb.load_mar);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_n = 0;
        #1;
        tests++;
        if (cb.load_mar !== 1'b1 || cb.marmux_sel !== marmux_pc || cb.mem_read !== 1'b0) begin
            fails++; $display("FAIL reset_release: load_mar %0d marmux %0d mem_read %0d, want 1 0 0",
                              cb.load_mar, cb.marmux_sel, cb.mem_read);
        end
    endtask

    task automatic test_alu();
        opcode = op_imm; funct3 = 3'd0; funct7 = 7'h00;
        run_instr(0, 0);
        tests++;
        if (n_cyc !== 5 || n_rf !== 1 || n_pc !== 1) begin
            fails++; $display("FAIL addi_seq: cyc %0d rf %0d pc %0d, want 5 1 1", n_cyc, n_rf, n_pc);
        end
        tests++;
        if (rf_aluop !== alu_add || rf_sel !== rfmux_alu_out || pc_sel !== pcmux_pc_plus4) begin
            fails++; $display("FAIL addi_sel: aluop %0d rfmux %0d pcmux %0d, want 0 0 0", rf_aluop, rf_sel, pc_sel);
        end
        opcode = op_reg; funct3 = 3'd0; funct7 = 7'h20;
        run_instr(0, 0);
        tests++;
        if (n_cyc !== 5 || rf_aluop !== alu_sub || rf_sel !== rfmux_alu_out) begin
            fails++; $display("FAIL sub: cyc %0d aluop %0d rfmux %0d, want 5 3 0", n_cyc, rf_aluop, rf_sel);
        end
        opcode = op_imm; funct3 = 3'd5; funct7 = 7'h20;
        run_instr(0, 0);
        tests++;
        if (rf_aluop !== alu_sra) begin fails++; $display("FAIL srai: aluop %0d, want 2", rf_aluop); end
        opcode = op_imm; funct3 = 3'd0; funct7 = 7'h20;
        run_instr(0, 0);
        tests++;
        if (rf_aluop !== alu_add) begin fails++; $display("FAIL addi_f7: aluop %0d, want 0", rf_aluop); end
        opcode = op_imm; funct3 = 3'd3; funct7 = 7'h00;
        run_instr(0, 0);
        tests++;
        if (rf_sel !== rfmux_br_en || rf_cmpmux !== 1'b1 || rf_cmpop !== bltu) begin
            fails++; $display("FAIL sltiu: rfmux %0d cmpmux %0d cmpop %0d, want 1 1 6", rf_sel, rf_cmpmux, rf_cmpop);
        end
        opcode = op_reg; funct3 = 3'd2; funct7 = 7'h00;
        run_instr(0, 0);
        tests++;
        if (rf_sel !== rfmux_br_en || rf_cmpmux !== 1'b0 || rf_cmpop !== blt) begin
            fails++; $display("FAIL slt: rfmux %0d cmpmux %0d cmpop %0d, want 1 0 4", rf_sel, rf_cmpmux, rf_cmpop);
        end
        opcode = op_lui; funct3 = 3'd0;
        run_instr(0, 0);
        tests++;
        if (n_cyc !== 5 || rf_sel !== rfmux_u_imm) begin
            fails++; $display("FAIL lui: cyc %0d rfmux %0d, want 5 2", n_cyc, rf_sel);
        end
    endtask

    task automatic test_branch();
        opcode = op_br; funct3 = 3'd0; br_en = 1'b1;
        run_instr(0, 0);
        tests++;
        if (n_cyc !== 5 || n_pc !== 1 || pc_sel !== pcmux_alu_out || n_rf !== 0 || pc_cmpop !== beq) begin
            fails++; $display("FAIL beq_taken: cyc %0d pc %0d pcmux %0d rf %0d cmpop %0d, want 5 1 1 0 0",
                              n_cyc, n_pc, pc_sel, n_rf, pc_cmpop);
        end
        funct3 = 3'd1; br_en = 1'b0;
        run_instr(0, 0);
        tests++;
        if (n_pc !== 1 || pc_sel !== pcmux_pc_plus4 || n_rf !== 0 || pc_cmpop !== bne) begin
            fails++; $display("FAIL bne_not_taken: pc %0d pcmux %0d rf %0d cmpop %0d, want 1 0 0 1",
                              n_pc, pc_sel, n_rf, pc_cmpop);
        end
    endtask

    task automatic test_jump();
        opcode = op_jal;
        run_instr(0, 0);
        tests++;
        if (n_cyc !== 5 || pc_sel !== pcmux_alu_out || rf_sel !== rfmux_pc_plus4 || n_rf !== 1) begin
            fails++; $display("FAIL jal: cyc %0d pcmux %0d rfmux %0d rf %0d, want 5 1 4 1", n_cyc, pc_sel, rf_sel, n_rf);
        end
        opcode = op_jalr;
        run_instr(0, 0);
        tests++;
        if (pc_sel !== pcmux_alu_mod2 || rf_sel !== rfmux_pc_plus4) begin
            fails++; $display("FAIL jalr: pcmux %0d rfmux %0d, want 2 4", pc_sel, rf_sel);
        end
    endtask

    task automatic test_store();
        opcode = op_store; funct3 = 3'd0; addr_lo = 2'd3;
        run_instr(0, 2);
        tests++;
        if (n_wr !== 3 || wr_be !== 4'b1000 || n_pc !== 1 || n_cyc !== 8 || n_ldo !== 1) begin
            fails++; $display("FAIL sb_wait: wr %0d be %h pc %0d cyc %0d ldo %0d, want 3 8 1 8 1",
                              n_wr, wr_be, n_pc, n_cyc, n_ldo);
        end
        funct3 = 3'd1; addr_lo = 2'd2;
        run_instr(0, 0);
        tests++;
        if (wr_be !== 4'b1100 || n_wr !== 1) begin
            fails++; $display("FAIL sh_lane: be %h wr %0d, want c 1", wr_be, n_wr);
        end
        funct3 = 3'd2; addr_lo = 2'd0;
        run_instr(0, 1);
        tests++;
        if (wr_be !== 4'hF || n_cyc !== 7 || n_rf !== 0) begin
            fails++; $display("FAIL sw: be %h cyc %0d rf %0d, want f 7 0", wr_be, n_cyc, n_rf);
        end
    endtask

    task automatic test_load();
        opcode = op_load; funct3 = 3'd5; addr_lo = 2'd2;
        run_instr(0, 1);
        tests++;
        if (n_cyc !== 8 || rf_mdr !== 3'd5 || rf_sel !== rfmux_mdr || n_rf !== 1 || n_wr !== 0) begin
            fails++; $display("FAIL lhu: cyc %0d mdrmux %0d rfmux %0d rf %0d wr %0d, want 8 5 3 1 0",
                              n_cyc, rf_mdr, rf_sel, n_rf, n_wr);
        end
        funct3 = 3'd0; addr_lo = 2'd1;
        run_instr(0, 1);
        tests++;
        if (n_cyc !== 8 || rf_mdr !== 3'd0) begin
            fails++; $display("FAIL lb: cyc %0d mdrmux %0d, want 8 0", n_cyc, rf_mdr);
        end
    endtask

    task automatic test_illegal();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opcode = 7'h00; funct3 = 3'd0;
        run_instr(0, 0);
        tests++;
        if (n_cyc !== 4 || n_pc !== 1 || pc_sel !== pcmux_pc_plus4 || n_rf !== 0) begin
            fails++; $display("FAIL illegal_skip: cyc %0d pc %0d pcmux %0d rf %0d, want 4 1 0 0", n_cyc, n_pc, pc_sel, n_rf);
        end
        act = 0;
        repeat (10) begin
            if (hb.mem_read || hb.mem_write || hb.load_pc || hb.load_mar || hb.load_ir || hb.load_regfile) act++;
            @(negedge clk);
        end
        tests++;
        if (act !== 0) begin fails++; $display("FAIL illegal_halt: active cycles %0d, want 0", act); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_jump();
        test_store();
        test_load();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
